uart_receiver: RTL and testbench

Serial-to-parallel UART receiver for the ULX3S design. It samples the asynchronous `rx` pin and recovers 8N1 frames, or 8E1 frames when parity is compiled in. Each received byte is presented on `data` with a single-cycle `data_ready` strobe. It is the receive-side counterpart of the byte producer feeding our UART transmitter, and loopback tests use it to check incrementing byte streams.

---
 rtl/uart_pkg.sv | 27 ++
 rtl/sync_2ff.sv | 26 ++
 rtl/uart_receiver.sv | 195 +++++++++++++++++++
 tb/tb_uart_receiver.sv | 267 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// uart_pkg: shared definitions for the UART receive path.
//   rx_state_e                 receiver FSM state encodings (3-bit)
//   UART_DEFAULT_CLKS_PER_BIT  25 MHz / 115200 baud
//   UART_DATA_BITS, UART_LAST_BIT_IDX, UART_FRAME_BITS  frame length constants
// Build option: UART_RX_PARITY_EN selects 8E1 framing instead of 8N1.
package uart_pkg;

   typedef enum logic [2:0] {
      sIDLE    = 3'd0,
      sSTART   = 3'd1,
      sDATA    = 3'd2,
      sPARITY  = 3'd3,
      sSTOP    = 3'd4,
      sRECOVER = 3'd5
   } rx_state_e;

   localparam int unsigned UART_DEFAULT_CLKS_PER_BIT = 217;
   localparam int unsigned UART_DATA_BITS            = 8;
   localparam logic [2:0]  UART_LAST_BIT_IDX         = 3'(UART_DATA_BITS - 1);

`ifdef UART_RX_PARITY_EN
   localparam int unsigned UART_FRAME_BITS = 11;
`else
   localparam int unsigned UART_FRAME_BITS = 10;
`endif

endpackage

// File: rtl/sync_2ff.sv
// sync_2ff: generic 1-bit two-flop synchroniser for asynchronous pin inputs.
// Resets to 1 so an idle-high serial line looks idle straight out of reset.
//   clk_i   sampling clock
//   rst_ni  asynchronous active-low reset
//   d_i     asynchronous input
//   q_o     synchronised output
module sync_2ff (
   input  logic clk_i,
   input  logic rst_ni,
   input  logic d_i,
   output logic q_o
);

   logic [1:0] sync_q;

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         sync_q <= 2'b11;
      end else begin
         sync_q <= {sync_q[0], d_i};
      end
   end

   assign q_o = sync_q[1];

endmodule

// File: rtl/uart_receiver.sv
// uart_receiver: serial-to-parallel UART receiver, 8N1 (or 8E1 when the
// UART_RX_PARITY_EN macro is defined). Samples each bit at mid-bit.
//   clk         system clock, rising edge
//   resetn      asynchronous active-low reset
//   rx          asynchronous serial line, idles high
//   data        last good byte, held until the next good frame
//   data_ready  one-cycle strobe when data updates
//   busy        high from start-bit detection until back in idle
//   frame_err   one-cycle strobe when the stop bit is sampled low
//   parity_err  one-cycle strobe on even-parity failure (0 without parity)
module uart_receiver
   import uart_pkg::*;
#(
   parameter int unsigned CLKS_PER_BIT = UART_DEFAULT_CLKS_PER_BIT
) (
   input  logic       clk,
   input  logic       resetn,
   input  logic       rx,
   output logic [7:0] data,
   output logic       data_ready,
   output logic       busy,
   output logic       frame_err,
   output logic       parity_err
);

   localparam int unsigned   CW        = $clog2(CLKS_PER_BIT);
   localparam logic [CW-1:0] BIT_LAST  = CW'(CLKS_PER_BIT - 1);
   localparam logic [CW-1:0] HALF_LAST = CW'(CLKS_PER_BIT / 2 - 1);

   logic          rx_s;
   rx_state_e     state_q, state_d;
   logic [CW-1:0] cnt_q, cnt_d;
   logic [2:0]    bit_q, bit_d;
   logic [7:0]    shift_q, shift_d;
   logic [7:0]    data_q, data_d;
   logic          ready_q, ready_d;
   logic          ferr_q, ferr_d;
   logic          perr_q, perr_d;
   logic          armed_q, armed_d;
   logic          par_fail;

   sync_2ff u_sync (
      .clk_i  (clk),
      .rst_ni (resetn),
      .d_i    (rx),
      .q_o    (rx_s)
   );

`ifdef UART_RX_PARITY_EN
   logic par_bad_q, par_bad_d;

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         par_bad_q <= 1'b0;
      end else begin
         par_bad_q <= par_bad_d;
      end
   end

   assign par_fail = par_bad_q;
`else
   assign par_fail = 1'b0;
`endif

   // State register
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         state_q <= sIDLE;
         cnt_q   <= '0;
         bit_q   <= '0;
         shift_q <= '0;
         data_q  <= '0;
         ready_q <= 1'b0;
         ferr_q  <= 1'b0;
         perr_q  <= 1'b0;
         armed_q <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         bit_q   <= bit_d;
         shift_q <= shift_d;
         data_q  <= data_d;
         ready_q <= ready_d;
         ferr_q  <= ferr_d;
         perr_q  <= perr_d;
         armed_q <= armed_d;
      end
   end

   // Next-state and datapath
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q + CW'(1);
      bit_d   = bit_q;
      shift_d = shift_q;
      data_d  = data_q;
      ready_d = 1'b0;
      ferr_d  = 1'b0;
      perr_d  = 1'b0;
      // Start detection is held off until the line has been seen high once
      // after reset, so a line stuck low cannot trigger a false frame.
      armed_d = armed_q | rx_s;
`ifdef UART_RX_PARITY_EN
      par_bad_d = par_bad_q;
`endif

      unique case (state_q)
         sIDLE: begin
            cnt_d = '0;
            bit_d = '0;
`ifdef UART_RX_PARITY_EN
            par_bad_d = 1'b0;
`endif
            if (armed_q && !rx_s) begin
               state_d = sSTART;
            end
         end

         sSTART: begin
            if (cnt_q == HALF_LAST) begin
               cnt_d   = '0;
               state_d = rx_s ? sIDLE : sDATA;
            end
         end

         sDATA: begin
            if (cnt_q == BIT_LAST) begin
               cnt_d   = '0;
               shift_d = {rx_s, shift_q[7:1]};
               bit_d   = bit_q + 3'd1;
               if (bit_q == UART_LAST_BIT_IDX) begin
`ifdef UART_RX_PARITY_EN
                  state_d = sPARITY;
`else
                  state_d = sSTOP;
`endif
               end
            end
         end

         sPARITY: begin
`ifdef UART_RX_PARITY_EN
            if (cnt_q == BIT_LAST) begin
               cnt_d     = '0;
               par_bad_d = (rx_s != ^shift_q);
               state_d   = sSTOP;
            end
`else
            cnt_d   = '0;
            state_d = sIDLE;
`endif
         end

         sSTOP: begin
            // Leaves at mid-stop-bit so a following start bit is not missed.
            if (cnt_q == BIT_LAST) begin
               cnt_d  = '0;
               perr_d = par_fail;
               if (rx_s) begin
                  state_d = sIDLE;
                  if (!par_fail) begin
                     data_d  = shift_q;
                     ready_d = 1'b1;
                  end
               end else begin
                  ferr_d  = 1'b1;
                  state_d = sRECOVER;
               end
            end
         end

         sRECOVER: begin
            cnt_d = '0;
            if (rx_s) begin
               state_d = sIDLE;
            end
         end

         default: begin
            cnt_d   = '0;
            state_d = sIDLE;
         end
      endcase
   end

   // Outputs
   always_comb begin
      busy       = (state_q != sIDLE);
      data       = data_q;
      data_ready = ready_q;
      frame_err  = ferr_q;
      parity_err = perr_q;
   end

endmodule

// File: tb/tb_uart_receiver.sv
module tb_uart_receiver;

   localparam int unsigned CPB = 16;
`ifdef UART_RX_PARITY_EN
   localparam bit PAR_EN = 1'b1;
`else
   localparam bit PAR_EN = 1'b0;
`endif

   logic       clk    = 1'b0;
   logic       resetn = 1'b0;
   logic       rx     = 1'b1;
   logic [7:0] data;
   logic       data_ready;
   logic       busy;
   logic       frame_err;
   logic       parity_err;

   int unsigned cyc = 0;
   int          errors = 0;
   int          checks = 0;

   logic [7:0]  got_q[$];
   int unsigned got_t[$];
   logic [7:0]  exp_q[$];
   logic [7:0]  last_good = 8'h00;
   int          fe_cnt = 0;
   int          pe_cnt = 0;
   int          fe_exp = 0;
   int          pe_exp = 0;

   uart_receiver #(.CLKS_PER_BIT(CPB)) dut (
      .clk        (clk),
      .resetn     (resetn),
      .rx         (rx),
      .data       (data),
      .data_ready (data_ready),
      .busy       (busy),
      .frame_err  (frame_err),
      .parity_err (parity_err)
   );

   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   always @(negedge clk) begin
      if (data_ready) begin
         got_q.push_back(data);
         got_t.push_back(cyc);
      end
      if (frame_err)  fe_cnt <= fe_cnt + 1;
      if (parity_err) pe_cnt <= pe_cnt + 1;
   end

   initial begin
      #400000;
      $display("FAIL watchdog: simulation time limit reached, errors=%0d", errors);
      $fatal(1, "watchdog");
   end

   task automatic tick(input int unsigned n);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   // Drives one frame and records what a correct receiver must report.
   task automatic send_frame(input logic [7:0] b, input logic stop_v, input logic par_ok);
      logic p;
      rx = 1'b0;
      tick(CPB);
      for (int i = 0; i < 8; i++) begin
         rx = b[i];
         tick(CPB);
      end
      p = (^b) ^ ~par_ok;
      if (PAR_EN) begin
         rx = p;
         tick(CPB);
      end
      rx = stop_v;
      tick(CPB);
      if (!stop_v) fe_exp++;
      if (PAR_EN && !par_ok) pe_exp++;
      if (stop_v && (!PAR_EN || par_ok)) begin
         exp_q.push_back(b);
         last_good = b;
      end
   endtask

   task automatic clear_q();
      got_q.delete();
      got_t.delete();
      exp_q.delete();
   endtask

   task automatic test_reset();
      resetn = 1'b0;
      rx     = 1'b1;
      tick(3);
      checks++; if (data !== 8'h00) begin errors++; $display("FAIL reset_data: got %h expected 00", data); end
      checks++; if (data_ready !== 1'b0) begin errors++; $display("FAIL reset_ready: got %b expected 0", data_ready); end
      checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b expected 0", busy); end
      checks++; if ({frame_err, parity_err} !== 2'b00) begin errors++; $display("FAIL reset_errs: got %b expected 00", {frame_err, parity_err}); end
      resetn = 1'b1;
      tick(4);
   endtask

   task automatic test_back_to_back();
      int unsigned t_start;
      int unsigned dt;
      clear_q();
      t_start = cyc;
      send_frame(8'h55, 1'b1, 1'b1);
      send_frame(8'hA3, 1'b1, 1'b1);
      rx = 1'b1;
      tick(CPB);
      checks++; if (got_q.size() !== 2) begin errors++; $display("FAIL b2b_count: got %0d expected 2", got_q.size()); end
      if (got_q.size() >= 2) begin
         checks++; if (got_q[0] !== exp_q[0]) begin errors++; $display("FAIL b2b_byte0: got %h expected %h", got_q[0], exp_q[0]); end
         checks++; if (got_q[1] !== exp_q[1]) begin errors++; $display("FAIL b2b_byte1: got %h expected %h", got_q[1], exp_q[1]); end
         // 9.5 bit-times to mid-stop, plus synchroniser and register latency
         dt = got_t[0] - t_start;
         checks++; if (dt < (CPB * 19 / 2 + 2) || dt > (CPB * 19 / 2 + 4)) begin errors++; $display("FAIL b2b_latency: got %0d cycles expected %0d..%0d", dt, CPB * 19 / 2 + 2, CPB * 19 / 2 + 4); end
      end
      checks++; if (fe_cnt !== fe_exp) begin errors++; $display("FAIL b2b_frame_err: got %0d expected %0d", fe_cnt, fe_exp); end
      checks++; if (pe_cnt !== pe_exp) begin errors++; $display("FAIL b2b_parity_err: got %0d expected %0d", pe_cnt, pe_exp); end
   endtask

   task automatic test_glitch();
      int unsigned n;
      clear_q();
      rx = 1'b0;
      tick(4);
      checks++; if (busy !== 1'b1) begin errors++; $display("FAIL glitch_busy_rise: got %b expected 1", busy); end
      rx = 1'b1;
      n = 0;
      while (busy && n <= CPB / 2 + 2) begin
         tick(1);
         n++;
      end
      checks++; if (busy !== 1'b0) begin errors++; $display("FAIL glitch_busy_fall: busy=%b after %0d cycles expected 0", busy, n); end
      tick(2 * CPB);
      checks++; if (got_q.size() !== 0) begin errors++; $display("FAIL glitch_no_data: got %0d pulses expected 0", got_q.size()); end
      checks++; if (fe_cnt !== fe_exp) begin errors++; $display("FAIL glitch_no_ferr: got %0d expected %0d", fe_cnt, fe_exp); end
   endtask

   task automatic test_frame_error();
      int unsigned n;
      clear_q();
      send_frame(8'h3C, 1'b0, 1'b1);
      tick(3 * CPB);
      checks++; if (busy !== 1'b1) begin errors++; $display("FAIL ferr_busy_held: got %b expected 1", busy); end
      checks++; if (fe_cnt !== fe_exp) begin errors++; $display("FAIL ferr_count: got %0d expected %0d", fe_cnt, fe_exp); end
      checks++; if (got_q.size() !== 0) begin errors++; $display("FAIL ferr_no_data: got %0d pulses expected 0", got_q.size()); end
      checks++; if (data !== last_good) begin errors++; $display("FAIL ferr_data_kept: got %h expected %h", data, last_good); end
      rx = 1'b1;
      n = 0;
      while (busy && n < 6) begin
         tick(1);
         n++;
      end
      checks++; if (busy !== 1'b0) begin errors++; $display("FAIL ferr_busy_release: busy=%b after %0d cycles expected 0", busy, n); end
      tick(CPB);
   endtask

   task automatic test_reset_midframe();
      clear_q();
      rx = 1'b0;
      tick(CPB);
      for (int i = 0; i < 4; i++) begin
         rx = 1'b1;
         tick(CPB);
      end
      rx = 1'b1;
      tick(CPB / 2);
      resetn = 1'b0;
      #1;
      last_good = 8'h00;
      checks++; if (data !== 8'h00) begin errors++; $display("FAIL midrst_data: got %h expected 00", data); end
      checks++; if (busy !== 1'b0) begin errors++; $display("FAIL midrst_busy: got %b expected 0", busy); end
      tick(3);
      resetn = 1'b1;
      tick(2 * CPB);
      send_frame(8'h12, 1'b1, 1'b1);
      rx = 1'b1;
      tick(CPB);
      checks++; if (got_q.size() !== 1) begin errors++; $display("FAIL midrst_count: got %0d expected 1", got_q.size()); end
      if (got_q.size() >= 1) begin
         checks++; if (got_q[0] !== 8'h12) begin errors++; $display("FAIL midrst_byte: got %h expected 12", got_q[0]); end
      end
   endtask

   task automatic test_stream();
      clear_q();
      for (int i = 1; i <= 8; i++) send_frame(8'(i), 1'b1, 1'b1);
      rx = 1'b1;
      tick(CPB);
      checks++; if (got_q.size() !== exp_q.size()) begin errors++; $display("FAIL stream_count: got %0d expected %0d", got_q.size(), exp_q.size()); end
      for (int i = 0; i < got_q.size() && i < exp_q.size(); i++) begin
         checks++; if (got_q[i] !== exp_q[i]) begin errors++; $display("FAIL stream_byte%0d: got %h expected %h", i, got_q[i], exp_q[i]); end
         if (i > 0) begin
            checks++; if (!(got_q[i] > got_q[i-1])) begin errors++; $display("FAIL stream_incr%0d: got %h after %h expected larger", i, got_q[i], got_q[i-1]); end
         end
      end
   endtask

   task automatic test_random();
      logic [7:0] b;
      logic       stop_v;
      logic       par_ok;
      clear_q();
      for (int k = 0; k < 12; k++) begin
         b      = 8'($urandom_range(0, 255));
         stop_v = ($urandom_range(0, 4) != 0);
         par_ok = ($urandom_range(0, 3) != 0);
         send_frame(b, stop_v, par_ok);
         rx = 1'b1;
         // A broken stop bit needs the line high for a few cycles to recover.
         tick(stop_v ? $urandom_range(0, 20) : $urandom_range(4, 20));
      end
      rx = 1'b1;
      tick(CPB);
      checks++; if (got_q.size() !== exp_q.size()) begin errors++; $display("FAIL rand_count: got %0d expected %0d", got_q.size(), exp_q.size()); end
      for (int i = 0; i < got_q.size() && i < exp_q.size(); i++) begin
         checks++; if (got_q[i] !== exp_q[i]) begin errors++; $display("FAIL rand_byte%0d: got %h expected %h", i, got_q[i], exp_q[i]); end
      end
      checks++; if (fe_cnt !== fe_exp) begin errors++; $display("FAIL rand_frame_err: got %0d expected %0d", fe_cnt, fe_exp); end
      checks++; if (pe_cnt !== pe_exp) begin errors++; $display("FAIL rand_parity_err: got %0d expected %0d", pe_cnt, pe_exp); end
      checks++; if (data !== last_good) begin errors++; $display("FAIL rand_last_data: got %h expected %h", data, last_good); end
   endtask

`ifdef UART_RX_PARITY_EN
   task automatic test_parity();
      clear_q();
      send_frame(8'h07, 1'b1, 1'b0);
      rx = 1'b1;
      tick(CPB);
      checks++; if (pe_cnt !== pe_exp) begin errors++; $display("FAIL par_bad_pulse: got %0d expected %0d", pe_cnt, pe_exp); end
      checks++; if (got_q.size() !== 0) begin errors++; $display("FAIL par_bad_no_data: got %0d expected 0", got_q.size()); end
      send_frame(8'h07, 1'b1, 1'b1);
      rx = 1'b1;
      tick(CPB);
      checks++; if (got_q.size() !== 1) begin errors++; $display("FAIL par_good_count: got %0d expected 1", got_q.size()); end
      checks++; if (data !== 8'h07) begin errors++; $display("FAIL par_good_data: got %h expected 07", data); end
      checks++; if (pe_cnt !== pe_exp) begin errors++; $display("FAIL par_good_no_err: got %0d expected %0d", pe_cnt, pe_exp); end
   endtask
`endif

   initial begin
      test_reset();
      test_back_to_back();
      test_glitch();
      test_frame_error();
      test_reset_midframe();
      test_stream();
`ifdef UART_RX_PARITY_EN
      test_parity();
`endif
      test_random();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
